demux_rr_dispatcher: RTL and testbench
======================================

// Module: demux_rr_dispatcher
// PURPOSE
//  Sequencing controller for the 1-to-4 demux datapath (DW-bit word to one of four DW-bit lanes).
//  Accepts words on a valid/ready input and picks a destination lane: round-robin over enabled lanes,
//  or directed by a per-word dest field. The word is held in a single register until that lane's
//  consumer takes it.
//  Sits between a single producer and four lane consumers. Drives the lane select and the 4*DW-bit lane bus.
// PARAMETERS
//  DW     3   data word width per lane
//  NCH    4   lane count; fixed at 4 (2-bit select), must not be overridden
// PORTS
//  clk        in   1      rising-edge clock, single clock domain
//  rst        in   1      synchronous, active-high reset
//  mode       in   1      0 = round-robin over enabled lanes, 1 = directed by in_dest
//  lane_en    in   4      per-lane enable mask; bit i enables lane i
//  in_valid   in   1      producer word valid
//  in_data    in   DW     producer word
//  in_dest    in   2      destination lane; used only when mode = 1
//  in_ready   out  1      dispatcher can accept a word this cycle
//  out_valid  out  4      one-hot; bit i = lane i holds a word
//  out_data   out  4*DW   lane i occupies bits [DW*i+DW-1 : DW*i]; non-selected lanes are driven 0
//  out_ready  in   4      per-lane consumer ready
//  sel        out  2      lane currently targeted; meaningful only while busy
//  busy       out  1      holding register occupied
//  drop       out  1      1-cycle pulse: word accepted in directed mode toward a disabled lane and discarded
// BEHAVIOUR
//  Reset values: state=IDLE, rr_ptr=0, sel=0, busy=0, out_valid=0, out_data=0, drop=0, hold_data=0.
//  States
//   IDLE: in_ready = 1.
//   HOLD: in_ready = out_ready[sel] (completion cycle allows back-to-back pass-through).
//  Accept: a word is accepted when in_valid & in_ready.
//  Target selection on accept
//   mode 0: first enabled lane at or after rr_ptr, wrapping 3->0.
//   mode 0, lane_en == 0: in_ready forced 0 in IDLE; no accept.
//   mode 1: target = in_dest. If lane_en[in_dest] == 0, the word is accepted, drop pulses the
//    next cycle, the state is unchanged, and nothing is emitted.
//  Timing
//   Accepted word appears on lanes 1 cycle after accept: state=HOLD, sel=target,
//    out_valid=1<<target, its out_data slice = word, all other slices 0.
//   Latency is exactly 1 cycle from accept to out_valid when the lane is not back-pressured.
//  Completion: in HOLD with out_ready[sel]=1, the transfer completes that cycle.
//   mode 0: rr_ptr <= sel+1 (mod 4). mode 1: rr_ptr is unchanged.
//   A simultaneous accept loads the next word: HOLD continues with the new target; no bubble.
//   No simultaneous accept: next state IDLE; out_valid=0, out_data=0.
//  HOLD stability: out_valid, sel and out_data stay constant until completion.
//   Changes to mode, lane_en or out_ready of other lanes have no effect on a held word.
//   Disabling lane sel while in HOLD does not cancel it.
//  Exclusivity: out_valid is at most one-hot. in_ready never depends combinationally on in_valid.
//  Reset mid-operation: the held word is discarded. Outputs take reset values the next cycle; no partial emit.
//  Round-robin fairness: with all lanes enabled and always ready, consecutive words go to lanes 0,1,2,3,0,...
// STRUCTURE
//  Shared package demux_pkg: typedef lane_sel_t = logic[1:0]; localparam NCH=4; state enum {IDLE,HOLD}.
//  One sub-module: rr_pick — combinational "first set bit of a 4-bit mask at or after ptr, with wrap";
//   outputs found and idx. The top holds the FSM, hold register, rr_ptr and the lane-bus drive.
// TESTING
//  1. Reset, mode 0, lane_en=1111, out_ready=1111, stream din=3'b111 x5
//     -> out_valid 0001,0010,0100,1000,0001 on consecutive cycles; in_ready stays 1.
//  2. mode 0, lane_en=1010, 4 words
//     -> lanes 1,3,1,3; out_data only in bits[5:3] or [11:9], all other bits 0.
//  3. mode 1, in_dest=2, out_ready[2]=0 for 3 cycles, din=3'b101
//     -> out_valid=0100 and out_data[8:6]=101 held stable; in_ready=0 until out_ready[2]=1, completes next edge.
//  4. mode 1, lane_en=1110, in_dest=0
//     -> accepted, drop=1 for exactly 1 cycle, out_valid stays 0000, busy stays 0.
//  5. rst asserted while HOLD on lane 3
//     -> next cycle out_valid=0, out_data=0, busy=0, rr_ptr=0; next mode-0 word goes to lane 0.
//  6. mode 0, lane_en=0000, in_valid=1 -> in_ready=0, no accept.
//     Then lane_en=0100 -> word dispatched to lane 2.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types for the 1-to-4 demux dispatcher: lane select width, lane count, FSM states.
package demux_pkg;
    localparam int NCH = 4;
    typedef logic [1:0] lane_sel_t;
    typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;
endpackage

// File: rtl/demux_rr_dispatcher_rr_pick.sv
// Combinational round-robin search: first set bit of a 4-bit mask at or after ptr, wrapping 3->0.
module rr_pick
    import demux_pkg::*;
(
    input  logic [3:0] mask,
    input  lane_sel_t  ptr,
    output logic       found,
    output lane_sel_t  idx
);
    always_comb begin
        found = |mask;
        idx   = ptr;
        // Walk the offsets from farthest to nearest so the nearest hit wins.
        for (int i = 3; i >= 0; i--) begin
            if (mask[lane_sel_t'(ptr + lane_sel_t'(i))])
                idx = lane_sel_t'(ptr + lane_sel_t'(i));
        end
    end
endmodule

// File: rtl/demux_rr_dispatcher.sv
// Single-register dispatcher: accepts a word, routes it to one of four lanes (round-robin or
// directed), and holds it until that lane's consumer takes it.
module demux_rr_dispatcher #(
    parameter int DW  = 3,
    parameter int NCH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [3:0]        lane_en,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_data,
    input  logic [1:0]        in_dest,
    output logic              in_ready,
    output logic [NCH-1:0]    out_valid,
    output logic [NCH*DW-1:0] out_data,
    input  logic [NCH-1:0]    out_ready,
    output logic [1:0]        sel,
    output logic              busy,
    output logic              drop
);
    import demux_pkg::*;

    state_t        state;
    lane_sel_t     rr_ptr;
    lane_sel_t     ptr_eff;
    lane_sel_t     pick_idx;
    lane_sel_t     target;
    logic          pick_found;
    logic          can_target;
    logic          completing;
    logic          accept;
    logic          deliver;
    logic [DW-1:0] hold_data;

    assign busy       = (state == HOLD);
    assign completing = busy && out_ready[sel];

    // A word accepted in the completion cycle must see the advanced pointer,
    // otherwise back-to-back round-robin traffic would revisit the same lane.
    assign ptr_eff = (completing && !mode) ? lane_sel_t'(sel + 2'd1) : rr_ptr;

    rr_pick u_pick (
        .mask  (lane_en),
        .ptr   (ptr_eff),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign target     = mode ? in_dest : pick_idx;
    assign can_target = mode || pick_found;
    assign in_ready   = (!busy || out_ready[sel]) && can_target;
    assign accept     = in_valid && in_ready;
    assign deliver    = accept && (!mode || lane_en[in_dest]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            sel       <= '0;
            hold_data <= '0;
            drop      <= 1'b0;
        end else begin
            drop <= accept && mode && !lane_en[in_dest];
            if (completing && !mode)
                rr_ptr <= lane_sel_t'(sel + 2'd1);
            if (deliver) begin
                state     <= HOLD;
                sel       <= target;
                hold_data <= in_data;
            end else if (completing) begin
                state     <= IDLE;
                hold_data <= '0;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        assign out_valid[i]            = busy && (sel == lane_sel_t'(i));
        assign out_data[DW*i +: DW]    = out_valid[i] ? hold_data : '0;
    end
endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Directed bench for demux_rr_dispatcher: one task per scenario, inline expected-value checks.
module tb_demux_rr_dispatcher;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic [3:0]    lane_en;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [1:0]    in_dest;
    logic          in_ready;
    logic [3:0]    out_valid;
    logic [4*DW-1:0] out_data;
    logic [3:0]    out_ready;
    logic [1:0]    sel;
    logic          busy;
    logic          drop;

    int passed = 0;
    int total  = 0;

    demux_rr_dispatcher #(.DW(DW), .NCH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .lane_en   (lane_en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; lane_en = 4'b0000; in_valid = 1'b0;
        in_data = '0; in_dest = 2'd0; out_ready = 4'b0000;
        tick(); tick();
        total++;
        if ({out_valid, out_data, busy, drop, sel} !== 20'd0)
            $display("FAIL reset: valid=%b data=%h busy=%b drop=%b sel=%0d, required all 0",
                     out_valid, out_data, busy, drop, sel);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_rr_stream();
        logic [3:0] exp_v [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        mode = 1'b0; lane_en = 4'b1111; out_ready = 4'b1111;
        in_valid = 1'b1; in_data = 3'b111;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL rr_ready_idle: in_ready=%b, required 1", in_ready);
        else passed++;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                @(posedge clk); #1; in_valid = 1'b0;
            end else tick();
            total++;
            if (out_valid !== exp_v[k] || (k < 4 && in_ready !== 1'b1))
                $display("FAIL rr_stream word%0d: valid=%b ready=%b, required %b ready 1",
                         k, out_valid, in_ready, exp_v[k]);
            else passed++;
        end
        tick();
        total++;
        if (out_valid !== 4'b0000 || busy !== 1'b0)
            $display("FAIL rr_stream_drain: valid=%b busy=%b, required 0000 0", out_valid, busy);
        else passed++;
    endtask

    task automatic test_rr_sparse();
        // Pointer sits at 1 after the previous stream ended on lane 0.
        logic [2:0]  words [4] = '{3'b011, 3'b110, 3'b101, 3'b001};
        logic [3:0]  exp_v [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        logic [11:0] exp_d [4] = '{12'h018, 12'hC00, 12'h028, 12'h200};
        mode = 1'b0; lane_en = 4'b1010; out_ready = 4'b1111; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = words[k];
            tick();
            total++;
            if (out_valid !== exp_v[k] || out_data !== exp_d[k])
                $display("FAIL rr_sparse word%0d: valid=%b data=%h, required %b %h",
                         k, out_valid, out_data, exp_v[k], exp_d[k]);
            else passed++;
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) $display("FAIL rr_sparse_drain: busy=%b, required 0", busy);
        else passed++;
    endtask

    task automatic test_backpressure();
        mode = 1'b1; lane_en = 4'b1111; out_ready = 4'b1011;
        in_dest = 2'd2; in_data = 3'b101; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            // Unrelated input changes must not disturb the held word.
            lane_en = (c == 1) ? 4'b0000 : 4'b1111;
            mode = (c == 2) ? 1'b0 : 1'b1;
            #1;
            total++;
            if (out_valid !== 4'b0100 || out_data !== 12'h140 || in_ready !== 1'b0 || sel !== 2'd2)
                $display("FAIL bp_hold cyc%0d: valid=%b data=%h ready=%b sel=%0d, required 0100 140 0 2",
                         c, out_valid, out_data, in_ready, sel);
            else passed++;
            tick();
        end
        mode = 1'b1; lane_en = 4'b1111; out_ready = 4'b1111;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 4'b0100)
            $display("FAIL bp_release: ready=%b valid=%b, required 1 0100", in_ready, out_valid);
        else passed++;
        tick();
        total++;
        if (out_valid !== 4'b0000 || out_data !== 12'h000)
            $display("FAIL bp_complete: valid=%b data=%h, required 0000 000", out_valid, out_data);
        else passed++;
    endtask

    task automatic test_drop();
        mode = 1'b1; lane_en = 4'b1110; out_ready = 4'b1111;
        in_dest = 2'd0; in_data = 3'b011; in_valid = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL drop_ready: in_ready=%b, required 1", in_ready);
        else passed++;
        tick();
        in_valid = 1'b0;
        total++;
        if (drop !== 1'b1 || out_valid !== 4'b0000 || busy !== 1'b0)
            $display("FAIL drop_pulse: drop=%b valid=%b busy=%b, required 1 0000 0", drop, out_valid, busy);
        else passed++;
        tick();
        total++;
        if (drop !== 1'b0 || busy !== 1'b0)
            $display("FAIL drop_end: drop=%b busy=%b, required 0 0", drop, busy);
        else passed++;
    endtask

    task automatic test_reset_mid();
        // Advance the pointer to 1 so the post-reset lane-0 choice proves the pointer cleared.
        mode = 1'b0; lane_en = 4'b1111; out_ready = 4'b1111; in_valid = 1'b1; in_data = 3'b010;
        tick();
        in_valid = 1'b0;
        tick();
        mode = 1'b1; in_dest = 2'd3; out_ready = 4'b0111; in_valid = 1'b1; in_data = 3'b100;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 4'b1000 || busy !== 1'b1)
            $display("FAIL rstmid_hold: valid=%b busy=%b, required 1000 1", out_valid, busy);
        else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (out_valid !== 4'b0000 || out_data !== 12'h000 || busy !== 1'b0 || sel !== 2'd0)
            $display("FAIL rstmid_clear: valid=%b data=%h busy=%b sel=%0d, required 0000 000 0 0",
                     out_valid, out_data, busy, sel);
        else passed++;
        mode = 1'b0; out_ready = 4'b1111; in_valid = 1'b1; in_data = 3'b110;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 4'b0001 || out_data !== 12'h006)
            $display("FAIL rstmid_ptr: valid=%b data=%h, required 0001 006", out_valid, out_data);
        else passed++;
        tick();
    endtask

    task automatic test_no_lanes();
        mode = 1'b0; lane_en = 4'b0000; out_ready = 4'b1111; in_valid = 1'b1; in_data = 3'b011;
        #1;
        total++;
        if (in_ready !== 1'b0) $display("FAIL nolane_ready: in_ready=%b, required 0", in_ready);
        else passed++;
        tick();
        total++;
        if (busy !== 1'b0 || out_valid !== 4'b0000)
            $display("FAIL nolane_idle: busy=%b valid=%b, required 0 0000", busy, out_valid);
        else passed++;
        lane_en = 4'b0100;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL lane2_ready: in_ready=%b, required 1", in_ready);
        else passed++;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 4'b0100 || out_data !== 12'h0C0)
            $display("FAIL lane2_dispatch: valid=%b data=%h, required 0100 0c0", out_valid, out_data);
        else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_rr_stream();
        test_rr_sparse();
        test_backpressure();
        test_drop();
        test_reset_mid();
        test_no_lanes();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
